// File: rtl/serial_to_parallel_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_to_parallel_if
// Brief    : Serial-in / word-out bus between a bit source and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_to_parallel_if #(
    parameter int DATA_SIZE = 64
);
    localparam int C_CNT_W = $clog2(DATA_SIZE);

    logic                 DATA;
    logic                 SHIFT_EN;
    logic                 CLEAR;
    logic                 READY;
    logic [DATA_SIZE-1:0] DATA_OUT;
    logic                 VALID;
    logic [C_CNT_W-1:0]   BIT_COUNT;
    logic                 OVERRUN;

    modport master (
        output DATA, SHIFT_EN, CLEAR, READY,
        input  DATA_OUT, VALID, BIT_COUNT, OVERRUN
    );

    modport slave (
        input  DATA, SHIFT_EN, CLEAR, READY,
        output DATA_OUT, VALID, BIT_COUNT, OVERRUN
    );
endinterface
`default_nettype wire

// File: rtl/serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module   : serial_to_parallel
// Brief    : LSB-first deserializer with a double-buffered valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel #(
    parameter int DATA_SIZE = 64
) (
    input  wire logic            CLK,
    input  wire logic            RST_N,
    serial_to_parallel_if.slave  bus
);
    localparam int                 C_CNT_W = $clog2(DATA_SIZE);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(DATA_SIZE - 1);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } hold_state_t;

    hold_state_t          r_state;
    // Only the upper DATA_SIZE-1 bits of the shift register are ever read back;
    // the bit that falls off the bottom is never needed.
    logic [DATA_SIZE-2:0] r_sr;
    logic [C_CNT_W-1:0]   r_bit_count;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_overrun;

    logic [DATA_SIZE-1:0] w_word;
    logic                 w_complete;
    logic                 w_pop;

    assign w_word     = {bus.DATA, r_sr};
    assign w_complete = bus.SHIFT_EN && (r_bit_count == C_LAST);
    assign w_pop      = (r_state == S_FULL) && bus.READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_EMPTY;
            r_sr        <= '0;
            r_bit_count <= '0;
            r_data_out  <= '0;
            r_overrun   <= 1'b0;
        end else if (bus.CLEAR) begin
            r_state     <= S_EMPTY;
            r_sr        <= '0;
            r_bit_count <= '0;
            r_data_out  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (bus.SHIFT_EN) begin
                r_sr        <= w_word[DATA_SIZE-1:1];
                r_bit_count <= w_complete ? '0 : r_bit_count + 1'b1;
            end
            case (r_state)
                S_EMPTY: begin
                    if (w_complete) begin
                        r_data_out <= w_word;
                        r_state    <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_complete && w_pop) begin
                        r_data_out <= w_word;
                    end else if (w_complete) begin
                        // Consumer still owns the held word: drop the new one.
                        r_overrun  <= 1'b1;
                    end else if (w_pop) begin
                        r_state    <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign bus.DATA_OUT  = r_data_out;
    assign bus.VALID     = (r_state == S_FULL);
    assign bus.BIT_COUNT = r_bit_count;
    assign bus.OVERRUN   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_to_parallel
// Brief    : Self-checking bench for 8-bit and 64-bit deserializer instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel;
    logic CLK;
    logic RST_N;

    serial_to_parallel_if #(.DATA_SIZE(8))  if8  ();
    serial_to_parallel_if #(.DATA_SIZE(64)) if64 ();

    serial_to_parallel #(.DATA_SIZE(8))  u_dut8  (.CLK(CLK), .RST_N(RST_N), .bus(if8.slave));
    serial_to_parallel #(.DATA_SIZE(64)) u_dut64 (.CLK(CLK), .RST_N(RST_N), .bus(if64.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          size;
        int          cnt;
        logic [63:0] acc;
        logic [63:0] data;
        bit          valid;
        bit          ovr;
    } model_t;

    int          errors = 0;
    int          checks = 0;
    model_t      m8;
    model_t      m64;
    logic [63:0] pop8[$];
    logic [63:0] pop64[$];

    function automatic model_t model_init(int size);
        model_t m;
        m.size = size; m.cnt = 0; m.acc = '0; m.data = '0; m.valid = 0; m.ovr = 0;
        return m;
    endfunction

    // Word assembly by bit position: bit k of the stream lands at weight 2^k.
    function automatic model_t model_next(model_t m, bit d, bit se, bit clr, bit rdy);
        model_t      n;
        bit          pop;
        bit          done;
        logic [63:0] word;
        n    = m;
        pop  = m.valid && rdy;
        done = 0;
        word = '0;
        if (clr) return model_init(m.size);
        if (se) begin
            n.acc = m.acc | (64'(d) << m.cnt);
            n.cnt = m.cnt + 1;
            if (n.cnt == m.size) begin
                done  = 1;
                word  = n.acc;
                n.cnt = 0;
                n.acc = '0;
            end
        end
        if (done && (!m.valid || pop)) begin
            n.data  = word;
            n.valid = 1;
        end else if (done) begin
            n.ovr = 1;
        end else if (pop) begin
            n.valid = 0;
        end
        return n;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes, advance both models, compare every output.
    task automatic tick(string tag);
        if (if8.VALID && if8.READY && !if8.CLEAR)    pop8.push_back(64'(if8.DATA_OUT));
        if (if64.VALID && if64.READY && !if64.CLEAR) pop64.push_back(if64.DATA_OUT);
        @(posedge CLK);
        m8  = model_next(m8,  if8.DATA,  if8.SHIFT_EN,  if8.CLEAR,  if8.READY);
        m64 = model_next(m64, if64.DATA, if64.SHIFT_EN, if64.CLEAR, if64.READY);
        #1;
        chk({tag, ".d8.data"},  64'(if8.DATA_OUT),   m8.data);
        chk({tag, ".d8.valid"}, 64'(if8.VALID),      64'(m8.valid));
        chk({tag, ".d8.cnt"},   64'(if8.BIT_COUNT),  64'(m8.cnt));
        chk({tag, ".d8.ovr"},   64'(if8.OVERRUN),    64'(m8.ovr));
        chk({tag, ".d64.data"}, if64.DATA_OUT,       m64.data);
        chk({tag, ".d64.valid"},64'(if64.VALID),     64'(m64.valid));
        chk({tag, ".d64.cnt"},  64'(if64.BIT_COUNT), 64'(m64.cnt));
        chk({tag, ".d64.ovr"},  64'(if64.OVERRUN),   64'(m64.ovr));
    endtask

    task automatic send8(string tag, logic [7:0] w, bit gaps);
        for (int i = 0; i < 8; i++) begin
            while (gaps && ($urandom % 3 == 0)) begin
                if8.SHIFT_EN = 1'b0;
                tick(tag);
            end
            if8.DATA     = w[i];
            if8.SHIFT_EN = 1'b1;
            tick(tag);
        end
        if8.SHIFT_EN = 1'b0;
        if8.DATA     = 1'b0;
    endtask

    initial begin
        logic [63:0] w64;
        logic [63:0] sent[$];
        logic [63:0] tx_sr;
        int          tx_bits;
        logic        tx_out;
        bit          strobe;
        bit          strobe_d;
        int          loaded;
        int          budget;

        RST_N = 1'b1;
        {if8.DATA, if8.SHIFT_EN, if8.CLEAR, if8.READY}     = '0;
        {if64.DATA, if64.SHIFT_EN, if64.CLEAR, if64.READY} = '0;
        m8  = model_init(8);
        m64 = model_init(64);
        #1 RST_N = 1'b0;
        #2;
        chk("reset.d8.data",  64'(if8.DATA_OUT), 64'd0);
        chk("reset.d8.valid", 64'(if8.VALID),    64'd0);
        chk("reset.d64.data", if64.DATA_OUT,     64'd0);
        @(negedge CLK) RST_N = 1'b1;

        // Asynchronous reset mid-word with a word already held.
        send8("pre_reset", 8'h96, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if8.DATA = 1'b1; if8.SHIFT_EN = 1'b1; tick("pre_reset");
        end
        if8.SHIFT_EN = 1'b0;
        chk("pre_reset.cnt", 64'(if8.BIT_COUNT), 64'd5);
        #1 RST_N = 1'b0;
        #1;
        chk("async_reset.data",  64'(if8.DATA_OUT),  64'd0);
        chk("async_reset.valid", 64'(if8.VALID),     64'd0);
        chk("async_reset.cnt",   64'(if8.BIT_COUNT), 64'd0);
        chk("async_reset.ovr",   64'(if8.OVERRUN),   64'd0);
        m8  = model_init(8);
        m64 = model_init(64);
        #2 RST_N = 1'b1;
        send8("after_reset", 8'hA5, 1'b0);
        chk("after_reset.data",  64'(if8.DATA_OUT), 64'hA5);
        chk("after_reset.valid", 64'(if8.VALID),    64'd1);

        // Single 64-bit word with random strobe gaps.
        w64 = 64'hDEADBEEF01234567;
        for (int i = 0; i < 64; i++) begin
            while ($urandom % 3 == 0) begin
                if64.SHIFT_EN = 1'b0; tick("word64");
            end
            if64.DATA = w64[i]; if64.SHIFT_EN = 1'b1;
            tick("word64");
            if (i == 62) chk("word64.valid_early", 64'(if64.VALID), 64'd0);
        end
        if64.SHIFT_EN = 1'b0;
        chk("word64.valid", 64'(if64.VALID),     64'd1);
        chk("word64.data",  if64.DATA_OUT,       64'hDEADBEEF01234567);
        chk("word64.cnt",   64'(if64.BIT_COUNT), 64'd0);
        if64.READY = 1'b1; tick("word64_pop");
        if64.READY = 1'b0;
        chk("word64_pop.valid", 64'(if64.VALID), 64'd0);

        // Back-to-back words; the second completes on the same edge as a pop.
        if8.READY = 1'b1; tick("b2b_flush");
        pop8.delete();
        send8("b2b", 8'h01, 1'b0);
        if8.READY = 1'b0;
        w64 = 64'h80;
        for (int i = 0; i < 8; i++) begin
            if8.DATA = w64[i]; if8.SHIFT_EN = 1'b1;
            if (i == 7) if8.READY = 1'b1;
            tick("b2b");
        end
        send8("b2b", 8'hFF, 1'b0);
        tick("b2b_tail"); tick("b2b_tail");
        chk("b2b.pops",  64'(pop8.size()),     64'd3);
        if (pop8.size() == 3) begin
            chk("b2b.pop0", pop8[0], 64'h01);
            chk("b2b.pop1", pop8[1], 64'h80);
            chk("b2b.pop2", pop8[2], 64'hFF);
        end
        chk("b2b.ovr", 64'(if8.OVERRUN), 64'd0);

        // Overrun: second word dropped while the first is unconsumed.
        if8.READY = 1'b0;
        send8("ovr", 8'h3C, 1'b1);
        send8("ovr", 8'hC3, 1'b1);
        chk("ovr.data",  64'(if8.DATA_OUT), 64'h3C);
        chk("ovr.flag",  64'(if8.OVERRUN),  64'd1);
        pop8.delete();
        if8.READY = 1'b1; tick("ovr_pop");
        if8.READY = 1'b0;
        chk("ovr_pop.word",  (pop8.size() == 1) ? pop8[0] : 64'hX, 64'h3C);
        chk("ovr_pop.valid", 64'(if8.VALID),   64'd0);
        chk("ovr_pop.flag",  64'(if8.OVERRUN), 64'd1);

        // Clear after 3 bits, colliding with a shift strobe.
        for (int i = 0; i < 3; i++) begin
            if8.DATA = 1'b1; if8.SHIFT_EN = 1'b1; tick("clear_pre");
        end
        if8.CLEAR = 1'b1; if8.DATA = 1'b1; if8.SHIFT_EN = 1'b1;
        tick("clear");
        if8.CLEAR = 1'b0; if8.SHIFT_EN = 1'b0;
        chk("clear.cnt",   64'(if8.BIT_COUNT), 64'd0);
        chk("clear.valid", 64'(if8.VALID),     64'd0);
        chk("clear.ovr",   64'(if8.OVERRUN),   64'd0);
        send8("clear_post", 8'h5A, 1'b1);
        chk("clear_post.data",  64'(if8.DATA_OUT), 64'h5A);
        chk("clear_post.valid", 64'(if8.VALID),    64'd1);

        // Loopback from a registered-output transmitter, strobe delayed a cycle.
        pop64.delete();
        if64.READY = 1'b1;
        tx_sr = '0; tx_bits = 0; tx_out = 1'b0; strobe_d = 0; loaded = 0; budget = 0;
        while (pop64.size() < 300 && budget < 60000) begin
            if (tx_bits == 0 && loaded < 300) begin
                tx_sr = {$urandom, $urandom};
                sent.push_back(tx_sr);
                tx_bits = 64;
                loaded++;
            end
            strobe = (tx_bits > 0) && ($urandom % 4 != 0);
            if64.DATA     = tx_out;
            if64.SHIFT_EN = strobe_d;
            tick("loop");
            if (strobe) begin
                tx_out  = tx_sr[0];
                tx_sr   = tx_sr >> 1;
                tx_bits = tx_bits - 1;
            end
            strobe_d = strobe;
            budget++;
        end
        chk("loop.count", 64'(pop64.size()), 64'd300);
        for (int i = 0; i < pop64.size() && i < sent.size(); i++)
            chk($sformatf("loop.word%0d", i), pop64[i], sent[i]);
        chk("loop.ovr", 64'(if64.OVERRUN), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
